// File: rtl/dbus_gpio_pkg.sv
// Shared data-bus payload types, peripheral address constants and GPIO register
// map used by the GPIO responder and the interconnect.
package dbus_gpio_pkg;

    localparam int unsigned DBUS_AW    = 32;
    localparam int unsigned DBUS_DW    = 32;
    localparam int unsigned DBUS_BE_W  = DBUS_DW / 8;
    localparam int unsigned GPIO_OFF_W = 3;

    // Interconnect address match for the GPIO window (addr[31:5] compared).
    localparam logic [DBUS_AW-1:0] GPIO_ADDR_MATCH = 32'h4000_0000;
    localparam logic [DBUS_AW-1:0] GPIO_ADDR_MASK  = 32'hFFFF_FFE0;

    localparam logic [GPIO_OFF_W-1:0] GPIO_OUT_OFF = 3'd0;
    localparam logic [GPIO_OFF_W-1:0] GPIO_DIR_OFF = 3'd1;
    localparam logic [GPIO_OFF_W-1:0] GPIO_IN_OFF  = 3'd2;
    localparam logic [GPIO_OFF_W-1:0] GPIO_IE_OFF  = 3'd3;
    localparam logic [GPIO_OFF_W-1:0] GPIO_IP_OFF  = 3'd4;

    typedef enum logic {
        GPIO_IDLE = 1'b0,
        GPIO_ACK  = 1'b1
    } type_gpio_fsm_e;

    typedef struct packed {
        logic [DBUS_AW-1:0]   addr;
        logic [DBUS_DW-1:0]   w_data;
        logic [DBUS_BE_W-1:0] sel_byte;
        logic                 req;
        logic                 w_en;
    } type_dbus2peri_s;

    typedef struct packed {
        logic [DBUS_DW-1:0] r_data;
        logic               ack;
    } type_peri2dbus_s;

    // Expand byte enables into a per-bit write mask.
    function automatic logic [DBUS_DW-1:0] byte_mask(input logic [DBUS_BE_W-1:0] be);
        logic [DBUS_DW-1:0] m;
        m = '0;
        for (int k = 0; k < int'(DBUS_BE_W); k++) begin
            m[k*8 +: 8] = {8{be[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Per-bit multi-flop synchronizer for asynchronous pad inputs.
// Ports: clk, rst_n, d_i (async inputs), q_o (synchronized outputs).
module gpio_sync #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dbus_gpio.sv
// GPIO responder on the data bus: OUT/DIR/IN/IE/IP registers, rising-edge
// interrupt pending bits and a level interrupt to the PLIC.
// Ports: clk, rst_n, dbus2peri_i/gpio_sel_i (request), gpio2dbus_o (response),
// gpio_in_i (pads), gpio_out_o, gpio_oe_o, gpio_irq_o.
module dbus_gpio
    import dbus_gpio_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  type_dbus2peri_s       dbus2peri_i,
    input  logic                  gpio_sel_i,
    output type_peri2dbus_s       gpio2dbus_o,
    input  logic [GPIO_WIDTH-1:0] gpio_in_i,
    output logic [GPIO_WIDTH-1:0] gpio_out_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe_o,
    output logic                  gpio_irq_o
);

    type_gpio_fsm_e        state_q;
    logic [GPIO_OFF_W-1:0] off_q;
    logic                  wen_q;
    logic [DBUS_DW-1:0]    wdata_q;
    logic [DBUS_BE_W-1:0]  be_q;

    logic [GPIO_WIDTH-1:0] out_q, out_d;
    logic [GPIO_WIDTH-1:0] dir_q, dir_d;
    logic [GPIO_WIDTH-1:0] ie_q, ie_d;
    logic [GPIO_WIDTH-1:0] ip_q, ip_d;
    logic [GPIO_WIDTH-1:0] in_prev_q;
    logic [GPIO_WIDTH-1:0] in_sync;
    logic                  irq_q;

    logic [GPIO_WIDTH-1:0] wr_mask;
    logic [GPIO_WIDTH-1:0] wr_data;
    logic [GPIO_WIDTH-1:0] rise;
    logic                  ack_c;
    logic [DBUS_DW-1:0]    rdata_c;
    logic                  unused_addr;

    gpio_sync #(
        .WIDTH  (GPIO_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (gpio_in_i),
        .q_o   (in_sync)
    );

    // Handshake FSM; request fields are captured on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GPIO_IDLE;
            off_q   <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            case (state_q)
                GPIO_IDLE: begin
                    if (gpio_sel_i && dbus2peri_i.req) begin
                        off_q   <= dbus2peri_i.addr[4:2];
                        wen_q   <= dbus2peri_i.w_en;
                        wdata_q <= dbus2peri_i.w_data;
                        be_q    <= dbus2peri_i.sel_byte;
                        state_q <= GPIO_ACK;
                    end
                end
                GPIO_ACK: state_q <= GPIO_IDLE;
                default:  state_q <= GPIO_IDLE;
            endcase
        end
    end

    assign ack_c       = (state_q == GPIO_ACK);
    assign wr_mask     = GPIO_WIDTH'(byte_mask(be_q));
    assign wr_data     = GPIO_WIDTH'(wdata_q);
    assign rise        = in_sync & ~in_prev_q;
    assign unused_addr = ^{dbus2peri_i.addr[DBUS_AW-1:5], dbus2peri_i.addr[1:0]};

    // Register next-state: lane-qualified writes in the ACK cycle; edge set beats W1C.
    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        ie_d  = ie_q;
        ip_d  = ip_q;
        if (ack_c && wen_q) begin
            case (off_q)
                GPIO_OUT_OFF: out_d = (out_q & ~wr_mask) | (wr_data & wr_mask);
                GPIO_DIR_OFF: dir_d = (dir_q & ~wr_mask) | (wr_data & wr_mask);
                GPIO_IE_OFF:  ie_d  = (ie_q  & ~wr_mask) | (wr_data & wr_mask);
                GPIO_IP_OFF:  ip_d  = ip_q & ~(wr_data & wr_mask);
                default:      ;
            endcase
        end
        ip_d = ip_d | rise;
    end

    // Read mux; data is forced to zero outside the ACK cycle.
    always_comb begin
        rdata_c = '0;
        if (ack_c) begin
            case (off_q)
                GPIO_OUT_OFF: rdata_c = DBUS_DW'(out_q);
                GPIO_DIR_OFF: rdata_c = DBUS_DW'(dir_q);
                GPIO_IN_OFF:  rdata_c = DBUS_DW'(in_sync);
                GPIO_IE_OFF:  rdata_c = DBUS_DW'(ie_q);
                GPIO_IP_OFF:  rdata_c = DBUS_DW'(ip_q);
                default:      rdata_c = '0;
            endcase
        end
    end

    // Register file, edge history and registered interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            dir_q     <= '0;
            ie_q      <= '0;
            ip_q      <= '0;
            in_prev_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            ie_q      <= ie_d;
            ip_q      <= ip_d;
            in_prev_q <= in_sync;
            irq_q     <= |(ip_q & ie_q);
        end
    end

    assign gpio2dbus_o.ack    = ack_c;
    assign gpio2dbus_o.r_data = rdata_c;
    assign gpio_out_o         = out_q;
    assign gpio_oe_o          = dir_q;
    assign gpio_irq_o         = irq_q;

endmodule

// File: tb/tb_dbus_gpio.sv
// Self-checking bench for dbus_gpio with a queue of expected read data.
module tb_dbus_gpio;
    import dbus_gpio_pkg::*;

    localparam int unsigned W = 32;

    logic            clk;
    logic            rst_n;
    type_dbus2peri_s bus;
    logic            sel;
    type_peri2dbus_s rsp;
    logic [W-1:0]    pins;
    logic [W-1:0]    gout;
    logic [W-1:0]    goe;
    logic            irq;

    int checks;
    int errors;
    logic [31:0] exp_q [$];

    dbus_gpio #(.GPIO_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dbus2peri_i (bus),
        .gpio_sel_i  (sel),
        .gpio2dbus_o (rsp),
        .gpio_in_i   (pins),
        .gpio_out_o  (gout),
        .gpio_oe_o   (goe),
        .gpio_irq_o  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] addr_of(input logic [2:0] off);
        return GPIO_ADDR_MATCH | (32'(off) << 2);
    endfunction

    // Issue one request; report whether/when ack came and the data seen with it.
    task automatic bus_xfer(input logic [2:0] off, input logic wen, input logic [31:0] wd,
                            input logic [3:0] be, output logic got, output int lat,
                            output logic [31:0] rd);
        @(negedge clk);
        bus.addr = addr_of(off); bus.w_data = wd; bus.sel_byte = be;
        bus.w_en = wen; bus.req = 1'b1; sel = 1'b1;
        got = 1'b0; lat = 0; rd = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            bus.req = 1'b0; sel = 1'b0; bus.w_en = 1'b0;
            if (rsp.ack) begin
                got = 1'b1; lat = i; rd = rsp.r_data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic got; int lat; logic [31:0] rd, e;
        repeat (3) @(negedge clk);
        checks++; if (rsp.ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", rsp.ack); end
        checks++; if (rsp.r_data !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rsp.r_data); end
        checks++; if ({gout, goe, irq} !== '0) begin errors++; $display("FAIL rst_outs got %h/%h/%b exp 0", gout, goe, irq); end
        rst_n = 1'b1;
        bus_xfer(GPIO_OUT_OFF, 1'b1, 32'hFFFF_FFFF, 4'hF, got, lat, rd);
        bus_xfer(GPIO_DIR_OFF, 1'b1, 32'hF0F0_F0F0, 4'hF, got, lat, rd);
        @(negedge clk);
        checks++; if (gout !== 32'hFFFF_FFFF) begin errors++; $display("FAIL pre_out got %h exp ffffffff", gout); end
        checks++; if (goe !== 32'hF0F0_F0F0) begin errors++; $display("FAIL pre_oe got %h exp f0f0f0f0", goe); end
        // Reset lands while the ACK cycle is in progress.
        bus.addr = addr_of(GPIO_OUT_OFF); bus.w_en = 1'b0; bus.sel_byte = 4'hF;
        bus.req = 1'b1; sel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0; sel = 1'b0;
        checks++; if (rsp.ack !== 1'b1) begin errors++; $display("FAIL midack_pre got %b exp 1", rsp.ack); end
        rst_n = 1'b0;
        #1;
        checks++; if (rsp.ack !== 1'b0) begin errors++; $display("FAIL midack_rst_ack got %b exp 0", rsp.ack); end
        checks++; if ({gout, goe, irq} !== '0) begin errors++; $display("FAIL midack_rst_outs got %h/%h/%b exp 0", gout, goe, irq); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(32'h0);
        bus_xfer(GPIO_OUT_OFF, 1'b0, 32'h0, 4'hF, got, lat, rd);
        e = exp_q.pop_front();
        checks++; if (got !== 1'b1 || lat != 1) begin errors++; $display("FAIL post_rst_lat got %0d exp 1", lat); end
        checks++; if (rd !== e) begin errors++; $display("FAIL post_rst_read got %h exp %h", rd, e); end
    endtask

    task automatic test_byte_lane();
        logic got; int lat; logic [31:0] rd, e;
        bus_xfer(GPIO_OUT_OFF, 1'b1, 32'hAABB_CCDD, 4'b0100, got, lat, rd);
        @(negedge clk);
        checks++; if (gout !== 32'h00BB_0000) begin errors++; $display("FAIL lane_out got %h exp 00bb0000", gout); end
        exp_q.push_back(32'h00BB_0000);
        bus_xfer(GPIO_OUT_OFF, 1'b0, 32'h0, 4'hF, got, lat, rd);
        e = exp_q.pop_front();
        checks++; if (got !== 1'b1 || lat != 1) begin errors++; $display("FAIL lane_lat got %0d exp 1", lat); end
        checks++; if (rd !== e) begin errors++; $display("FAIL lane_read got %h exp %h", rd, e); end
        bus_xfer(GPIO_DIR_OFF, 1'b1, 32'h1234_5678, 4'hF, got, lat, rd);
        bus_xfer(GPIO_DIR_OFF, 1'b1, 32'hFFFF_FFFF, 4'b0011, got, lat, rd);
        @(negedge clk);
        checks++; if (goe !== 32'h1234_FFFF) begin errors++; $display("FAIL lane_oe got %h exp 1234ffff", goe); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        logic exp_ack;
        exp_q.push_back(32'h1234_FFFF);
        exp_q.push_back(32'h1234_FFFF);
        @(negedge clk);
        bus.addr = addr_of(GPIO_DIR_OFF); bus.w_en = 1'b0; bus.sel_byte = 4'hF;
        bus.req = 1'b1; sel = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_ack = (c % 2) == 1;
            checks++; if (rsp.ack !== exp_ack) begin errors++; $display("FAIL b2b_ack c%0d got %b exp %b", c, rsp.ack, exp_ack); end
            if (exp_ack) begin
                e = exp_q.pop_front();
                checks++; if (rsp.r_data !== e) begin errors++; $display("FAIL b2b_rdata c%0d got %h exp %h", c, rsp.r_data, e); end
            end else begin
                checks++; if (rsp.r_data !== 32'h0) begin errors++; $display("FAIL b2b_idle_rdata c%0d got %h exp 0", c, rsp.r_data); end
            end
        end
        bus.req = 1'b0; sel = 1'b0;
    endtask

    task automatic test_edge_irq();
        logic got; int lat; logic [31:0] rd, e;
        bus_xfer(GPIO_IE_OFF, 1'b1, 32'h1, 4'hF, got, lat, rd);
        @(negedge clk);
        pins[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
        exp_q.push_back(32'h1);
        bus_xfer(GPIO_IP_OFF, 1'b0, 32'h0, 4'hF, got, lat, rd);
        e = exp_q.pop_front();
        checks++; if (got !== 1'b1 || rd !== e) begin errors++; $display("FAIL ip_read got %h exp %h", rd, e); end
        bus_xfer(GPIO_IP_OFF, 1'b1, 32'h1, 4'hF, got, lat, rd);
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b exp 1", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", irq); end
    endtask

    task automatic test_set_wins();
        logic got; int lat; logic [31:0] rd, e;
        @(negedge clk);
        pins[3] = 1'b1;
        @(negedge clk);
        bus.addr = addr_of(GPIO_IP_OFF); bus.w_data = 32'h8; bus.sel_byte = 4'hF;
        bus.w_en = 1'b1; bus.req = 1'b1; sel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0; sel = 1'b0; bus.w_en = 1'b0;
        checks++; if (rsp.ack !== 1'b1) begin errors++; $display("FAIL collide_ack got %b exp 1", rsp.ack); end
        exp_q.push_back(32'h8);
        bus_xfer(GPIO_IP_OFF, 1'b0, 32'h0, 4'hF, got, lat, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL set_wins got %h exp %h", rd, e); end
        bus_xfer(GPIO_IP_OFF, 1'b1, 32'h8, 4'hF, got, lat, rd);
        exp_q.push_back(32'h0);
        bus_xfer(GPIO_IP_OFF, 1'b0, 32'h0, 4'hF, got, lat, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL ip_w1c got %h exp %h", rd, e); end
        exp_q.push_back(32'h9);
        bus_xfer(GPIO_IN_OFF, 1'b0, 32'h0, 4'hF, got, lat, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL in_read got %h exp %h", rd, e); end
    endtask

    task automatic test_reserved();
        logic got; int lat; logic [31:0] rd, e;
        bus_xfer(3'd6, 1'b1, 32'hFFFF_FFFF, 4'hF, got, lat, rd);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL rsv_wr_ack got %b exp 1", got); end
        bus_xfer(GPIO_IN_OFF, 1'b1, 32'hFFFF_FFFF, 4'hF, got, lat, rd);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL in_wr_ack got %b exp 1", got); end
        @(negedge clk);
        checks++; if (gout !== 32'h00BB_0000 || goe !== 32'h1234_FFFF) begin errors++; $display("FAIL rsv_regs got %h/%h exp 00bb0000/1234ffff", gout, goe); end
        for (int o = 5; o <= 7; o++) begin
            exp_q.push_back(32'h0);
            bus_xfer(3'(o), 1'b0, 32'h0, 4'hF, got, lat, rd);
            e = exp_q.pop_front();
            checks++; if (got !== 1'b1 || rd !== e) begin errors++; $display("FAIL rsv_read off%0d got %h exp %h", o, rd, e); end
        end
        exp_q.push_back(32'h9);
        bus_xfer(GPIO_IN_OFF, 1'b0, 32'h0, 4'hF, got, lat, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL in_after_wr got %h exp %h", rd, e); end
        exp_q.push_back(32'h1);
        bus_xfer(GPIO_IE_OFF, 1'b0, 32'h0, 4'hF, got, lat, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL ie_read got %h exp %h", rd, e); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; sel = 1'b0; pins = '0;
        bus = '0;
        test_reset();
        test_byte_lane();
        test_back_to_back();
        test_edge_irq();
        test_set_wins();
        test_reserved();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
